// File: rtl/bsg_reset_sequencer_pkg.sv
// Shared types for the downstream reset sequencer: FSM encoding and retry counter sizing.
package bsg_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        FAIL = 3'd4
    } seq_state_e;

    // Keeps the retry counter at least one bit wide when no retries are allowed.
    function automatic int retry_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

    localparam int max_retries_def_lp = 3;
    localparam int retry_width_def_lp = retry_width(max_retries_def_lp);

endpackage

// File: rtl/bsg_reset_seq_counter.sv
// Clear/up counter with an equality compare against a programmable value.
// Tie match_val_i to all-ones to get a terminal-count flag.
module bsg_reset_seq_counter #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    input  logic [width_p-1:0] match_val_i,
    output logic               match_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (up_i)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign match_o = (count_q == match_val_i);

endmodule

// File: rtl/bsg_reset_sequencer.sv
// Drives a timed synchronous reset to a downstream block, then waits for its
// ready level with a timeout and a bounded number of reset retries.
module bsg_reset_sequencer
    import bsg_reset_sequencer_pkg::*;
#(
    parameter int lg_hold_cycles_p    = 4,
    parameter int lg_timeout_cycles_p = 10,
    parameter int max_retries_p       = max_retries_def_lp
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   start_v_i,
    output logic                                   start_ready_o,
    input  logic [lg_hold_cycles_p-1:0]            hold_cycles_i,
    output logic                                   dn_reset_o,
    input  logic                                   dn_ready_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   fail_o,
    output logic [retry_width(max_retries_p)-1:0]  retry_count_o
);

    localparam int rw_lp = retry_width(max_retries_p);
    localparam logic [rw_lp-1:0] max_retry_lp = rw_lp'(max_retries_p);

    seq_state_e                  state_q, state_d;
    logic [lg_hold_cycles_p-1:0] hold_r_q, hold_r_d;
    logic [rw_lp-1:0]            retry_q, retry_d;

    logic accept;
    logic hold_last;
    logic timeout;
    logic in_hold, in_wait;
    logic wait_exit;

    assign in_hold   = (state_q == HOLD);
    assign in_wait   = (state_q == WAIT);
    assign accept    = start_v_i & start_ready_o;
    assign wait_exit = in_wait & (dn_ready_i | timeout);

    bsg_reset_seq_counter #(.width_p(lg_hold_cycles_p)) hold_cnt (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clear_i     (accept | (in_hold & hold_last)),
        .up_i        (in_hold),
        .match_val_i (hold_r_q),
        .match_o     (hold_last)
    );

    bsg_reset_seq_counter #(.width_p(lg_timeout_cycles_p)) timeout_cnt (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clear_i     (accept | wait_exit),
        .up_i        (in_wait),
        .match_val_i ({lg_timeout_cycles_p{1'b1}}),
        .match_o     (timeout)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Ready is checked ahead of the timeout so a late ready still succeeds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, FAIL: if (accept) state_d = HOLD;
            HOLD:             if (hold_last) state_d = WAIT;
            WAIT: begin
                if (dn_ready_i)
                    state_d = DONE;
                else if (timeout)
                    state_d = (retry_q == max_retry_lp) ? FAIL : HOLD;
            end
            default:          state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready_o = 1'b0;
        dn_reset_o    = 1'b1;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        fail_o        = 1'b0;
        case (state_q)
            IDLE: start_ready_o = 1'b1;
            HOLD: busy_o = 1'b1;
            WAIT: begin
                busy_o     = 1'b1;
                dn_reset_o = 1'b0;
            end
            DONE: begin
                start_ready_o = 1'b1;
                done_o        = 1'b1;
                dn_reset_o    = 1'b0;
            end
            FAIL: begin
                start_ready_o = 1'b1;
                fail_o        = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        hold_r_d = hold_r_q;
        retry_d  = retry_q;
        if (accept) begin
            hold_r_d = hold_cycles_i;
            retry_d  = '0;
        end else if (in_wait & ~dn_ready_i & timeout & (retry_q != max_retry_lp)) begin
            retry_d = retry_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_r_q <= '0;
            retry_q  <= '0;
        end else begin
            hold_r_q <= hold_r_d;
            retry_q  <= retry_d;
        end
    end

    assign retry_count_o = retry_q;

endmodule

// File: tb/tb_bsg_reset_sequencer.sv
// Directed bench for bsg_reset_sequencer with a 16-cycle timeout and two retries.
module tb_bsg_reset_sequencer;

    localparam int lg_hold_lp    = 4;
    localparam int lg_timeout_lp = 4;
    localparam int retries_lp    = 2;
    localparam int wait_len_lp   = 1 << lg_timeout_lp;

    logic                  clk_i = 1'b0;
    logic                  reset_n_i;
    logic                  start_v_i;
    logic                  start_ready_o;
    logic [lg_hold_lp-1:0] hold_cycles_i;
    logic                  dn_reset_o;
    logic                  dn_ready_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  fail_o;
    logic [1:0]            retry_count_o;

    int checks = 0;
    int errors = 0;

    bsg_reset_sequencer #(
        .lg_hold_cycles_p    (lg_hold_lp),
        .lg_timeout_cycles_p (lg_timeout_lp),
        .max_retries_p       (retries_lp)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .start_v_i     (start_v_i),
        .start_ready_o (start_ready_o),
        .hold_cycles_i (hold_cycles_i),
        .dn_reset_o    (dn_reset_o),
        .dn_ready_i    (dn_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .fail_o        (fail_o),
        .retry_count_o (retry_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_n_i     = 1'b1;
        start_v_i     = 1'b0;
        hold_cycles_i = '0;
        dn_ready_i    = 1'b0;

        // reset asserted mid-cycle, outputs must follow without a clock edge
        #12 reset_n_i = 1'b0;
        #1;
        chk("rst_dn_reset", dn_reset_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_fail", fail_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_retry", retry_count_o, 0);
        chk("rst_start_ready", start_ready_o, 1);
        repeat (2) @(posedge clk_i);
        #2 reset_n_i = 1'b1;
        tick();
        chk("idle_dn_reset", dn_reset_o, 1);
        chk("idle_start_ready", start_ready_o, 1);

        // hold=3: reset high t+1..t+4, low at t+5, ready during t+9, done at t+10
        hold_cycles_i = 4'd3;
        start_v_i     = 1'b1;
        tick();
        start_v_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("h3_dn_reset_hi", dn_reset_o, 1);
            chk("h3_busy", busy_o, 1);
            chk("h3_start_ready", start_ready_o, 0);
            tick();
        end
        chk("h3_dn_reset_lo", dn_reset_o, 0);
        repeat (4) begin
            chk("h3_done_early", done_o, 0);
            tick();
        end
        dn_ready_i = 1'b1;
        tick();
        dn_ready_i = 1'b0;
        chk("h3_done", done_o, 1);
        chk("h3_retry", retry_count_o, 0);
        chk("h3_busy_done", busy_o, 0);
        chk("h3_dn_reset_done", dn_reset_o, 0);
        tick();
        chk("h3_done_sticky", done_o, 1);

        // ready never comes: three rounds then FAIL
        hold_cycles_i = 4'd1;
        start_v_i     = 1'b1;
        tick();
        start_v_i = 1'b0;
        chk("to_done_drop", done_o, 0);
        for (int r = 0; r <= retries_lp; r++) begin
            for (int h = 0; h < 2; h++) begin
                chk("to_hold_dn_reset", dn_reset_o, 1);
                chk("to_hold_retry", retry_count_o, r);
                tick();
            end
            for (int w = 0; w < wait_len_lp; w++) begin
                chk("to_wait_dn_reset", dn_reset_o, 0);
                chk("to_wait_busy", busy_o, 1);
                tick();
            end
        end
        chk("to_fail", fail_o, 1);
        chk("to_fail_retry", retry_count_o, 2);
        chk("to_fail_dn_reset", dn_reset_o, 1);
        chk("to_fail_busy", busy_o, 0);
        chk("to_fail_start_ready", start_ready_o, 1);

        // ready in the final timeout cycle wins
        hold_cycles_i = 4'd0;
        start_v_i     = 1'b1;
        tick();
        start_v_i = 1'b0;
        chk("late_retry_clr", retry_count_o, 0);
        chk("late_fail_drop", fail_o, 0);
        chk("late_hold_dn_reset", dn_reset_o, 1);
        tick();
        chk("late_wait_dn_reset", dn_reset_o, 0);
        repeat (wait_len_lp - 1) tick();
        chk("late_no_done_yet", done_o, 0);
        dn_ready_i = 1'b1;
        tick();
        dn_ready_i = 1'b0;
        chk("late_done", done_o, 1);
        chk("late_fail", fail_o, 0);
        chk("late_retry", retry_count_o, 0);

        // restart from DONE with hold=0; start during HOLD must be ignored
        hold_cycles_i = 4'd0;
        start_v_i     = 1'b1;
        tick();
        hold_cycles_i = 4'd5;
        chk("rs_done_drop", done_o, 0);
        chk("rs_dn_reset", dn_reset_o, 1);
        chk("rs_start_ready", start_ready_o, 0);
        tick();
        start_v_i = 1'b0;
        chk("rs_one_cycle_hold", dn_reset_o, 0);
        chk("rs_busy", busy_o, 1);
        repeat (wait_len_lp) tick();
        chk("rs_retry_hold", dn_reset_o, 1);
        chk("rs_retry1", retry_count_o, 1);
        tick();
        chk("rs_retry_wait", dn_reset_o, 0);
        repeat (3) tick();

        // async reset in WAIT with one retry used
        chk("ar_pre_retry", retry_count_o, 1);
        #2 reset_n_i = 1'b0;
        #1;
        chk("ar_dn_reset", dn_reset_o, 1);
        chk("ar_retry", retry_count_o, 0);
        chk("ar_busy", busy_o, 0);
        chk("ar_start_ready", start_ready_o, 1);
        #3 reset_n_i = 1'b1;
        tick();
        chk("ar_idle_dn_reset", dn_reset_o, 1);
        chk("ar_idle_done", done_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
